inst_fetch_unit: RTL and testbench

Instruction fetch front-end that sits directly upstream of the IF/ID pipeline register of the 5-stage MIPS datapath.
- Owns the fetch PC and issues single-outstanding requests to a variable-latency instruction memory.
- Buffers returned instructions with their PC+4 in a small queue.
- Presents the queue head to IF/ID, honouring the IF_ID_Write stall signal and branch/jump redirects (flush).

---
 rtl/inst_fetch_unit_pkg.sv | 20 ++
 rtl/inst_fetch_unit_if.sv | 10 +
 rtl/inst_fetch_unit_fetch_queue.sv | 66 ++++++
 rtl/inst_fetch_unit.sv | 88 ++++++++
 tb/tb_inst_fetch_unit.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package inst_fetch_unit_pkg;
  localparam int ADDR_W = 32;
  localparam logic [31:0] NOP_INST = 32'h00000000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]       inst;
    logic [ADDR_W-1:0] pcplus;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(3);
  endfunction
endpackage

// File: rtl/inst_fetch_unit_if.sv
// Single-outstanding request/ack bus between fetch unit and instruction memory.
interface inst_fetch_unit_if;
  logic                                  imem_req;
  logic [inst_fetch_unit_pkg::ADDR_W-1:0] imem_addr;
  logic                                  imem_ack;
  logic [31:0]                           imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/inst_fetch_unit_fetch_queue.sv
// Small FIFO of {inst, pc+4} entries; flush resets pointers and count only.
module fetch_queue
  import inst_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  fetch_entry_t             data_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o,
  output fetch_entry_t             head_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; validity comes from count alone.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign head_o  = mem_q[rd_ptr_q];
endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch PC owner: issues one request at a time and queues returned instructions for IF/ID.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Redirect,
  input  logic [ADDR_W-1:0]     RedirectAddr,
  input  logic                  IF_ID_Write,
  output logic                  InstValid,
  output logic [31:0]           InstOut,
  output logic [ADDR_W-1:0]     PCPlusOut,
  inst_fetch_unit_if.master     imem
);
  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              req;
  logic              ack_xfer;
  logic              push;
  logic              pop;
  logic              q_empty;
  logic              q_full;
  logic [$clog2(DEPTH):0] q_count;
  fetch_entry_t      q_head;
  fetch_entry_t      q_in;

  assign ack_xfer = req && imem.imem_ack;
  assign push     = (state_q == WAIT) && ack_xfer && !Redirect;
  assign pop      = !q_empty && IF_ID_Write && !Redirect;
  assign q_in     = '{inst: imem.imem_rdata, pcplus: fetch_pc_q + ADDR_W'(4)};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if (Redirect)  fetch_pc_d = word_align(RedirectAddr);
    else if (push) fetch_pc_d = fetch_pc_q + ADDR_W'(4);
    case (state_q)
      IDLE: begin
        // Entering WAIT reserves a queue slot, so a push can never overflow.
        if (!Redirect && !q_full) state_d = WAIT;
      end
      WAIT: begin
        if (ack_xfer)      state_d = IDLE;
        else if (Redirect) state_d = DISCARD;
      end
      DISCARD: begin
        if (ack_xfer) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req            = (state_q == WAIT) || (state_q == DISCARD);
    imem.imem_req  = req;
    imem.imem_addr = fetch_pc_q;
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (Redirect),
    .data_i  (q_in),
    .count_o (q_count),
    .empty_o (q_empty),
    .full_o  (q_full),
    .head_o  (q_head)
  );

  assign InstValid = !q_empty;
  assign InstOut   = (q_count == '0) ? NOP_INST      : q_head.inst;
  assign PCPlusOut = (q_count == '0) ? ADDR_W'(0)    : q_head.pcplus;
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed and random checks of inst_fetch_unit against a queue-based reference model.
module tb_inst_fetch_unit;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h00000000;

  logic        clk = 1'b0;
  logic        rst, Redirect, IF_ID_Write, InstValid;
  logic [31:0] RedirectAddr, InstOut, PCPlusOut;

  always #5 clk = ~clk;

  inst_fetch_unit_if imem_bus ();

  inst_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .Redirect     (Redirect),
    .RedirectAddr (RedirectAddr),
    .IF_ID_Write  (IF_ID_Write),
    .InstValid    (InstValid),
    .InstOut      (InstOut),
    .PCPlusOut    (PCPlusOut),
    .imem         (imem_bus)
  );

  int errors = 0;
  int checks = 0;

  // Model: queue of {inst, pc+4}, fetch pc, request outstanding, outstanding response to drop.
  logic [63:0] m_q[$];
  logic [31:0] m_pc;
  bit          m_out;
  bit          m_disc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_model(input string tag);
    logic [63:0] head;
    head = (m_q.size() != 0) ? m_q[0] : 64'h0;
    check({tag, ".valid"}, {31'b0, InstValid}, {31'b0, m_q.size() != 0});
    check({tag, ".inst"},  InstOut,   head[63:32]);
    check({tag, ".pcplus"}, PCPlusOut, head[31:0]);
    check({tag, ".req"},   {31'b0, imem_bus.imem_req}, {31'b0, m_out});
    check({tag, ".addr"},  imem_bus.imem_addr, m_pc);
  endtask

  task automatic model_step(input bit r, input bit rd, input logic [31:0] ra,
                            input bit w, input bit a, input logic [31:0] d);
    int sz;
    bit acked;
    sz    = m_q.size();
    acked = m_out && a;
    if (r) begin
      m_q.delete();
      m_out  = 0;
      m_disc = 0;
      m_pc   = RESET_PC;
      return;
    end
    if (rd) begin
      m_q.delete();
      m_pc = {ra[31:2], 2'b00};
      if (acked) begin
        m_out  = 0;
        m_disc = 0;
      end else if (m_out) begin
        m_disc = 1;
      end
      return;
    end
    if (sz != 0 && w) void'(m_q.pop_front());
    if (m_out) begin
      if (acked) begin
        if (!m_disc) begin
          m_q.push_back({d, m_pc + 32'd4});
          m_pc = m_pc + 32'd4;
        end
        m_out  = 0;
        m_disc = 0;
      end
    end else if (sz < DEPTH) begin
      m_out  = 1;
      m_disc = 0;
    end
  endtask

  task automatic tick(input string tag, input bit r, input bit rd, input logic [31:0] ra,
                      input bit w, input bit a, input logic [31:0] d);
    rst                 = r;
    Redirect            = rd;
    RedirectAddr        = ra;
    IF_ID_Write         = w;
    imem_bus.imem_ack   = a;
    imem_bus.imem_rdata = d;
    model_step(r, rd, ra, w, a, d);
    @(negedge clk);
    compare_model(tag);
  endtask

  initial begin
    rst = 1'b1; Redirect = 1'b0; RedirectAddr = '0; IF_ID_Write = 1'b0;
    imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = '0;
    @(negedge clk);

    // Reset and first fetch
    tick("rst0", 1, 0, 0, 0, 0, 0);
    tick("rst1", 1, 0, 0, 0, 0, 0);
    check("rst.valid", {31'b0, InstValid}, 32'd0);
    check("rst.req",   {31'b0, imem_bus.imem_req}, 32'd0);
    check("rst.addr",  imem_bus.imem_addr, RESET_PC);
    tick("t1.issue", 0, 0, 0, 0, 0, 0);
    check("t1.req",  {31'b0, imem_bus.imem_req}, 32'd1);
    check("t1.addr", imem_bus.imem_addr, 32'h0);
    tick("t1.ack", 0, 0, 0, 0, 1, 32'h20080005);
    check("t1.valid",  {31'b0, InstValid}, 32'd1);
    check("t1.inst",   InstOut, 32'h20080005);
    check("t1.pcplus", PCPlusOut, 32'h4);

    // Fill to DEPTH with IF/ID stalled
    for (int k = 0; k < 10; k++) tick("t2.fill", 0, 0, 0, 0, 1, 32'hA0000000 | k);
    check("t2.req",  {31'b0, imem_bus.imem_req}, 32'd0);
    check("t2.addr", imem_bus.imem_addr, 32'h10);
    check("t2.inst", InstOut, 32'h20080005);
    tick("t2.pop", 0, 0, 0, 1, 0, 0);
    check("t2.pop.pcplus", PCPlusOut, 32'h8);
    check("t2.pop.req", {31'b0, imem_bus.imem_req}, 32'd0);
    tick("t2.reissue", 0, 0, 0, 0, 0, 0);
    check("t2.reissue.req",  {31'b0, imem_bus.imem_req}, 32'd1);
    check("t2.reissue.addr", imem_bus.imem_addr, 32'h10);

    // Redirect during WAIT, late ack dropped
    tick("t3.redir", 0, 1, 32'h40, 0, 0, 0);
    check("t3.valid", {31'b0, InstValid}, 32'd0);
    check("t3.discard.req", {31'b0, imem_bus.imem_req}, 32'd1);
    tick("t3.wait", 0, 0, 0, 0, 0, 0);
    tick("t3.ack", 0, 0, 0, 0, 1, 32'hDEADBEEF);
    check("t3.drop.valid", {31'b0, InstValid}, 32'd0);
    tick("t3.next", 0, 0, 0, 0, 0, 0);
    check("t3.next.req",  {31'b0, imem_bus.imem_req}, 32'd1);
    check("t3.next.addr", imem_bus.imem_addr, 32'h40);

    // Redirect coincident with ack, count=2
    tick("t4.a", 0, 0, 0, 0, 1, 32'h11111111);
    tick("t4.b", 0, 0, 0, 0, 0, 0);
    tick("t4.c", 0, 0, 0, 0, 1, 32'h22222222);
    tick("t4.d", 0, 0, 0, 0, 0, 0);
    check("t4.pre.addr", imem_bus.imem_addr, 32'h48);
    tick("t4.redir", 0, 1, 32'h80, 0, 1, 32'hBAD0BAD0);
    check("t4.valid", {31'b0, InstValid}, 32'd0);
    check("t4.req",   {31'b0, imem_bus.imem_req}, 32'd0);
    check("t4.addr",  imem_bus.imem_addr, 32'h80);
    tick("t4.next", 0, 0, 0, 0, 0, 0);
    check("t4.next.req", {31'b0, imem_bus.imem_req}, 32'd1);

    // Push and pop in the same cycle
    tick("t5.a", 0, 0, 0, 0, 1, 32'hAAAA0001);
    tick("t5.b", 0, 0, 0, 0, 0, 0);
    tick("t5.pp", 0, 0, 0, 1, 1, 32'hBBBB0002);
    check("t5.valid",  {31'b0, InstValid}, 32'd1);
    check("t5.inst",   InstOut, 32'hBBBB0002);
    check("t5.pcplus", PCPlusOut, 32'h88);
    tick("t5.drain", 0, 0, 0, 1, 0, 0);
    check("t5.empty", {31'b0, InstValid}, 32'd0);

    // Top-of-memory wrap, then reset mid-request
    tick("t6.redir", 0, 1, 32'hFFFFFFFF, 0, 0, 0);
    check("t6.addr", imem_bus.imem_addr, 32'hFFFFFFFC);
    tick("t6.drop", 0, 0, 0, 0, 1, 0);
    tick("t6.issue", 0, 0, 0, 0, 0, 0);
    check("t6.issue.addr", imem_bus.imem_addr, 32'hFFFFFFFC);
    tick("t6.ack", 0, 0, 0, 0, 1, 32'hCCCC0003);
    check("t6.inst",   InstOut, 32'hCCCC0003);
    check("t6.pcplus", PCPlusOut, 32'h0);
    check("t6.wrap.addr", imem_bus.imem_addr, 32'h0);
    tick("t6.wait", 0, 0, 0, 0, 0, 0);
    tick("t6.rst", 1, 0, 0, 0, 0, 0);
    check("t6.rst.valid",  {31'b0, InstValid}, 32'd0);
    check("t6.rst.inst",   InstOut, 32'h0);
    check("t6.rst.pcplus", PCPlusOut, 32'h0);
    check("t6.rst.req",    {31'b0, imem_bus.imem_req}, 32'd0);
    tick("t6.lateack", 0, 0, 0, 0, 1, 32'hEEEEEEEE);
    check("t6.lateack.valid", {31'b0, InstValid}, 32'd0);

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      tick("rand",
           ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 7) == 0),
           $urandom(),
           bit'($urandom_range(0, 1)),
           ($urandom_range(0, 2) == 0),
           $urandom());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
